// File: rtl/jtag_shift_master.sv
// jtag_shift_master: command-driven JTAG master that generates TCK/TMS/TDI
// sequences for TAP reset, IR/DR shifts and idle clocks, capturing TDO.
`default_nettype none

module jtag_shift_master #(
  parameter int TCK_DIV = 2
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;
  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

  state_t      state;
  logic [1:0]  op;
  logic [5:0]  n;
  logic [31:0] data;
  logic [5:0]  bit_idx;
  logic [7:0]  div_cnt;

  // Scan ops lead in through Select-DR (and Select-IR for IR) before shifting.
  function automatic logic [5:0] prefix_len(input logic [1:0] f_op);
    return (f_op == OP_IR) ? 6'd4 : 6'd3;
  endfunction

  function automatic logic [5:0] total_bits(input logic [1:0] f_op, input logic [5:0] f_n);
    logic [5:0] t;
    case (f_op)
      OP_RESET: t = 6'd6;
      OP_IR:    t = f_n + 6'd6;
      OP_DR:    t = f_n + 6'd5;
      default:  t = f_n;
    endcase
    return t;
  endfunction

  // Returns {tms, tdi} for TCK bit k of the command.
  function automatic logic [1:0] bit_drive(input logic [1:0] f_op, input logic [5:0] f_n,
                                           input logic [31:0] f_data, input logic [5:0] k);
    logic [5:0] pre;
    logic [5:0] sidx;
    logic       tms;
    logic       tdi;
    pre  = prefix_len(f_op);
    sidx = k - pre;
    tms  = 1'b0;
    tdi  = 1'b0;
    case (f_op)
      OP_RESET: tms = (k < 6'd5);
      OP_IDLE:  tms = 1'b0;
      default: begin
        if (k < pre) begin
          tms = (k == 6'd0) || ((f_op == OP_IR) && (k == 6'd1));
        end else if (sidx < f_n) begin
          tms = (sidx == f_n - 6'd1);
          tdi = |(f_data & (32'd1 << sidx));
        end else begin
          tms = (sidx == f_n);
        end
      end
    endcase
    return {tms, tdi};
  endfunction

  logic [5:0] cmd_n;
  logic [5:0] cur_pre;
  logic [5:0] cur_sidx;
  logic       cur_shift;

  assign cmd_n     = 6'(cmd_len) + 6'd1;
  assign cur_pre   = prefix_len(op);
  assign cur_sidx  = bit_idx - cur_pre;
  assign cur_shift = ((op == OP_IR) || (op == OP_DR)) && (bit_idx >= cur_pre) && (cur_sidx < n);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state     <= IDLE;
      op        <= OP_RESET;
      n         <= 6'd0;
      data      <= 32'd0;
      bit_idx   <= 6'd0;
      div_cnt   <= 8'd0;
      tck_o     <= 1'b0;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op             <= cmd_op;
            n              <= cmd_n;
            data           <= cmd_data;
            bit_idx        <= 6'd0;
            div_cnt        <= 8'd0;
            {tms_o, tdi_o} <= bit_drive(cmd_op, cmd_n, cmd_data, 6'd0);
            rsp_data       <= 32'd0;
            state          <= LOW;
          end
        end
        LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            tck_o   <= 1'b1;
            state   <= HIGH;
            // TDO is captured on the very edge that raises TCK.
            if (cur_shift) begin
              rsp_data <= rsp_data | ({31'd0, tdo_i} << cur_sidx);
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            tck_o   <= 1'b0;
            if (bit_idx == total_bits(op, n) - 6'd1) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              bit_idx        <= bit_idx + 6'd1;
              {tms_o, tdi_o} <= bit_drive(op, n, data, bit_idx + 6'd1);
              state          <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/jtag_shift_master.md
JTAG_SHIFT_MASTER -- requirements
Module: jtag_shift_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning sys_clock cycles per TCK half-period; legal values are 1..255.
REQ-002 SHALL have port sys_clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_op  in  2  operation: 00 TAP reset, 01 shift IR, 10 shift DR, 11 idle clocks.
REQ-007 SHALL have port cmd_len  in  5  bit or cycle count minus one; n = cmd_len+1, range 1..32.
REQ-008 SHALL have port cmd_data  in  32  TDI data, shifted LSB first.
REQ-009 SHALL have port rsp_valid  out  1  response available.
REQ-010 SHALL have port rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-011 SHALL have port rsp_data  out  32  captured TDO bits.
REQ-012 SHALL have ports tck_o, tms_o and tdi_o  out  1  each, driven to the TAP pads.
REQ-013 SHALL have port tdo_i  in  1  TDO from the TAP.

Function
REQ-014 SHALL run an FSM with states IDLE, LOW, HIGH, RESP; cmd_ready = (state==IDLE).
REQ-015 SHALL, on acceptance, latch op, n and data, build the TMS/TDI bit sequence below, and enter LOW.
REQ-016 SHALL, per TCK bit: in LOW, drive tms_o/tdi_o for that bit with tck_o=0 for TCK_DIV cycles; in HIGH, drive tck_o=1 for TCK_DIV cycles.
REQ-017 SHALL register tdo_i on the same sys_clock edge at which tck_o goes 0->1.
REQ-018 SHALL keep tms_o and tdi_o stable throughout each HIGH phase.
REQ-019 SHALL use this sequence for op 00: TMS 1,1,1,1,1,0, giving 6 TCK and ending in Run-Test/Idle.
REQ-020 SHALL use this sequence for op 10: TMS 1,0,0; then n shift bits with TMS=0 except TMS=1 on the last bit; then TMS 1,0; total n+5 TCK.
REQ-021 SHALL use this sequence for op 01: TMS 1,1,0,0; then n shift bits as in REQ-020; then TMS 1,0; total n+6 TCK.
REQ-022 SHALL use this sequence for op 11: n TCK with TMS=0.
REQ-023 SHALL drive tdi_o = cmd_data[i] on shift bit i and tdi_o=0 on all other bits.
REQ-024 SHALL write TDO sampled on shift bit i into rsp_data[i]; bits at and above n SHALL be 0; rsp_data SHALL be 0 for ops 00 and 11.
REQ-025 SHALL leave HIGH after the last TCK bit, drive tck_o=0, set rsp_valid=1 and enter RESP.
REQ-026 SHALL hold rsp_valid and rsp_data stable in RESP until rsp_ready=1, then clear rsp_valid and return to IDLE; cmd_ready SHALL stay low throughout RESP.
REQ-027 SHALL hold tck_o=0 and tms_o/tdi_o at their last driven values while in IDLE or RESP.
REQ-028 SHALL sustain a TCK period of exactly 2*TCK_DIV sys_clock cycles, with no gaps between bits of one command.
REQ-029 SHALL ignore cmd_valid while not in IDLE; a command presented in the same cycle rsp_ready clears RESP SHALL NOT be accepted until the following cycle.

Reset
REQ-030 SHALL, on sys_reset asserted at any time including mid-shift, immediately force state=IDLE, tck_o=0, tms_o=1, tdi_o=0, rsp_valid=0 and rsp_data=0, and discard any command in progress.
REQ-031 SHALL leave cmd_ready=1 on the first cycle after reset deasserts; the TAP state is undefined until an op 00 is issued.

Verification
REQ-032 SHALL pass: op 00 with TCK_DIV=2 -> 6 tck_o rising edges, TMS sequence 1,1,1,1,1,0, each TCK period 4 cycles, rsp_data=0.
REQ-033 SHALL pass: op 10, cmd_len=7, cmd_data=0xA5, tdo_i tied to 1 -> 13 TCK, TDI on shift bits 1,0,1,0,0,1,0,1, rsp_data=0x000000FF.
REQ-034 SHALL pass: op 01, cmd_len=3, cmd_data=0x8, tdo_i tied to 0 -> 10 TCK, TMS sequence 1,1,0,0,0,0,0,1,1,0, rsp_data=0.
REQ-035 SHALL pass: op 10, cmd_len=31, cmd_data=0xDEADBEEF, tdo_i connected to a 32-bit shift-register TAP model preloaded with 0x12345678 -> rsp_data=0x12345678.
REQ-036 SHALL pass: rsp_ready held low for 20 cycles after rsp_valid -> rsp_valid and rsp_data stable, cmd_ready=0 and tck_o=0 throughout.
REQ-037 SHALL pass: sys_reset pulsed during the 5th TCK of a DR shift -> outputs at reset values within the same cycle, no rsp_valid afterwards, and the next command completes normally.
